// File: rtl/mmio_data_bus.sv
// mmio_data_bus: core data-port decoder onto a word RAM and MMIO console FIFO, cycle counter and halt register.
module mmio_data_bus #(
    parameter int DATA_W     = 32,
    parameter int RAM_DEPTH  = 256,
    parameter int MMIO_BASE  = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              mem_en,
    input  logic              mem_read,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              halted,
    output logic [DATA_W-1:0] halt_code,
    output logic              bad_addr
);
    localparam int RA = $clog2(RAM_DEPTH);
    localparam int FA = $clog2(FIFO_DEPTH);
    localparam logic [31:0] RAM_END = 32'(4 * RAM_DEPTH);
    localparam logic [31:0] MMIO_LO = 32'(MMIO_BASE);
    localparam logic [31:0] MMIO_HI = 32'(MMIO_BASE + 16);
    localparam logic [FA:0] DEPTH = (FA + 1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] ram  [RAM_DEPTH];
    logic [DATA_W-1:0] fifo [FIFO_DEPTH];
    logic [FA:0]       wr_q, wr_d, rd_q, rd_d, cnt, free;
    logic              ovf_q, ovf_d, halted_q, halted_d, bad_q, bad_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, code_q, code_d, cyc_q, cyc_d, mmio_rd, status;
    logic              is_ram, is_mmio, rd_en, wr_en, empty, full, pop, push_req, push, halt_wr, clr;
    logic [1:0]        off;

    always_comb begin
        off      = addr[3:2] - MMIO_LO[3:2];
        is_ram   = addr < RAM_END;
        is_mmio  = addr >= MMIO_LO && addr < MMIO_HI;
        rd_en    = mem_en && mem_read;
        wr_en    = mem_en && !mem_read;
        cnt      = wr_q - rd_q;
        free     = DEPTH - cnt;
        empty    = wr_q == rd_q;
        full     = cnt == DEPTH;
        pop      = !empty && tx_ready;
        push_req = wr_en && is_mmio && off == 2'd0 && !halted_q;
        // a pop in the same cycle frees the slot a full-FIFO push needs
        push     = push_req && (!full || pop);
        clr      = wr_en && is_mmio && off == 2'd1 && wdata[2];
        halt_wr  = wr_en && is_mmio && off == 2'd3 && !halted_q;
        wr_d     = push ? wr_q + 1'b1 : wr_q;
        rd_d     = pop ? rd_q + 1'b1 : rd_q;
        ovf_d    = clr ? 1'b0 : ovf_q | (push_req && full && !pop);
        halted_d = halted_q | halt_wr;
        code_d   = halt_wr ? wdata : code_q;
        cyc_d    = halted_q ? cyc_q : cyc_q + 1'b1;
        bad_d    = bad_q | (mem_en && !is_ram && !is_mmio);
        status   = {{(DATA_W-3){1'b0}}, ovf_q, full, empty};
        mmio_rd  = off == 2'd0 ? DATA_W'(free) : off == 2'd1 ? status : off == 2'd2 ? cyc_q : code_q;
        rdata_d  = !rd_en ? rdata_q : is_ram ? ram[addr[2 +: RA]] : is_mmio ? mmio_rd : '0;
    end

    always_ff @(posedge clk) begin
        if (wr_en && is_ram && !halted_q) ram[addr[2 +: RA]] <= wdata;
        if (push) fifo[wr_q[FA-1:0]] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q     <= '0;
            rd_q     <= '0;
            ovf_q    <= 1'b0;
            halted_q <= 1'b0;
            bad_q    <= 1'b0;
            rdata_q  <= '0;
            code_q   <= '0;
            cyc_q    <= '0;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            ovf_q    <= ovf_d;
            halted_q <= halted_d;
            bad_q    <= bad_d;
            rdata_q  <= rdata_d;
            code_q   <= code_d;
            cyc_q    <= cyc_d;
        end
    end

    assign rdata     = rdata_q;
    assign tx_valid  = !empty;
    assign tx_data   = empty ? '0 : fifo[rd_q[FA-1:0]];
    assign halted    = halted_q;
    assign halt_code = code_q;
    assign bad_addr  = bad_q;
endmodule
